// File: rtl/dmp_ordered_serializer.sv
// Gather-stage serializer: waits for every enabled thread's done pulse, then streams
// each enabled thread's partition in ascending thread-ID order as valid/ready beats.
module dmp_ordered_serializer #(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32,
  parameter int BEAT_NODES     = 8,
  parameter int DATA_WIDTH     = 64,
  localparam int TID_W         = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1
) (
  input  logic                                                         clock,
  input  logic                                                         reset_n,
  input  logic [NUM_HW_THREADS-1:0][NODES_IN_GRAPH-1:0][DATA_WIDTH-1:0] page_rank_gather,
  input  logic [NUM_HW_THREADS-1:0]                                    done,
  input  logic [NUM_HW_THREADS-1:0]                                    thread_enable,
  output logic [BEAT_NODES-1:0][DATA_WIDTH-1:0]                        out_data,
  output logic                                                         out_valid,
  input  logic                                                         out_ready,
  output logic [TID_W-1:0]                                             out_thread_id,
  output logic                                                         out_sop,
  output logic                                                         out_eop,
  output logic                                                         stream_start,
  output logic                                                         stream_done,
  // Named release_pulse because "release" is a reserved word in SystemVerilog.
  output logic                                                         release_pulse,
  output logic                                                         busy
);

  localparam int BEATS  = NODES_IN_GRAPH / BEAT_NODES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SEND,
    ST_RELEASE
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_HW_THREADS-1:0] done_seen_q, done_seen_d;
  logic [NUM_HW_THREADS-1:0] en_q, en_d;
  logic [TID_W-1:0]          tid_q, tid_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;

  logic [NUM_HW_THREADS*NODES_IN_GRAPH*DATA_WIDTH-1:0] gather_flat;
  logic [NUM_HW_THREADS-1:0] higher_mask;
  logic                      sync;
  logic                      send;
  logic                      last_beat;
  logic                      has_next;
  logic [TID_W-1:0]          next_tid;
  logic [TID_W-1:0]          first_tid;
  logic [TID_W-1:0]          start_tid;

  function automatic logic [TID_W-1:0] lowest_set(input logic [NUM_HW_THREADS-1:0] mask);
    logic [TID_W-1:0] r;
    r = '0;
    for (int i = NUM_HW_THREADS - 1; i >= 0; i--) begin
      if (mask[i]) r = TID_W'(i);
    end
    return r;
  endfunction

  assign gather_flat = page_rank_gather;
  assign sync        = (|thread_enable) && (&(done_seen_q | ~thread_enable));
  assign send        = (state_q == ST_SEND);
  assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));
  assign first_tid   = lowest_set(en_q);
  assign start_tid   = lowest_set(thread_enable);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    higher_mask = '0;
    for (int i = 0; i < NUM_HW_THREADS; i++) begin
      higher_mask[i] = en_q[i] && (i > int'(tid_q));
    end
  end

  assign has_next = |higher_mask;
  assign next_tid = lowest_set(higher_mask);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    tid_d   = tid_q;
    beat_d  = beat_q;
    // A done pulse coinciding with the release cycle must survive the clear.
    done_seen_d = ((state_q == ST_RELEASE) ? '0 : done_seen_q) | done;

    case (state_q)
      ST_WAIT: begin
        if (sync) begin
          en_d    = thread_enable;
          tid_d   = start_tid;
          beat_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (!last_beat) begin
            beat_d = beat_q + BEAT_W'(1);
          end else if (has_next) begin
            tid_d  = next_tid;
            beat_d = '0;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: state_d = ST_WAIT;
      default:    state_d = ST_WAIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WAIT;
      done_seen_q <= '0;
      en_q        <= '0;
      tid_q       <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      done_seen_q <= done_seen_d;
      en_q        <= en_d;
      tid_q       <= tid_d;
      beat_q      <= beat_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < BEAT_NODES; k++) begin
      int base;
      base = int'(tid_q) * NODES_IN_GRAPH + int'(beat_q) * BEAT_NODES + k;
      if (send) out_data[k] = gather_flat[base*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign out_valid     = send;
  assign out_thread_id = send ? tid_q : '0;
  assign out_sop       = send && (beat_q == '0);
  assign out_eop       = send && last_beat;
  assign stream_start  = out_sop && (tid_q == first_tid);
  assign stream_done   = out_eop && !has_next;
  assign release_pulse = (state_q == ST_RELEASE);
  assign busy          = (state_q != ST_WAIT);

endmodule

// File: tb/tb_dmp_ordered_serializer.sv
// Directed bench for dmp_ordered_serializer: a per-cycle vector table for ordering,
// masking and sync rules, plus hand sequences for backpressure, reset and a 1-thread build.
module tb_dmp_ordered_serializer;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Main instance: 4 threads, 8 nodes, 4 nodes per beat -> 2 beats per thread.
  logic [3:0][7:0][63:0] gather;
  logic [3:0]            done, en;
  logic [3:0][63:0]      out_data;
  logic                  out_valid, out_ready;
  logic [1:0]            out_tid;
  logic                  out_sop, out_eop, s_start, s_done, rel, busy;

  dmp_ordered_serializer #(
    .NUM_HW_THREADS(4), .NODES_IN_GRAPH(8), .BEAT_NODES(4), .DATA_WIDTH(64)
  ) dut (
    .clock(clock), .reset_n(reset_n), .page_rank_gather(gather), .done(done),
    .thread_enable(en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_thread_id(out_tid), .out_sop(out_sop), .out_eop(out_eop), .stream_start(s_start),
    .stream_done(s_done), .release_pulse(rel), .busy(busy)
  );

  // Degenerate instance: 1 thread, 1 beat per thread.
  logic [0:0][3:0][63:0] gather1;
  logic [0:0]            done1, en1;
  logic [3:0][63:0]      out_data1;
  logic                  out_valid1, out_ready1;
  logic [0:0]            out_tid1;
  logic                  out_sop1, out_eop1, s_start1, s_done1, rel1, busy1;

  dmp_ordered_serializer #(
    .NUM_HW_THREADS(1), .NODES_IN_GRAPH(4), .BEAT_NODES(4), .DATA_WIDTH(64)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .page_rank_gather(gather1), .done(done1),
    .thread_enable(en1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_thread_id(out_tid1), .out_sop(out_sop1), .out_eop(out_eop1), .stream_start(s_start1),
    .stream_done(s_done1), .release_pulse(rel1), .busy(busy1)
  );

  typedef struct {
    logic [3:0] done;
    logic [3:0] en;
    logic       ready;
    logic       valid;
    logic [1:0] tid;
    logic       beat;
    logic       sop, eop, start, sdone, rel, busy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [1:0] t, input logic b,
                            input logic sop, input logic eop, input logic st, input logic sd,
                            input logic rl, input logic bsy);
    logic [3:0][63:0] exp_data;
    for (int k = 0; k < 4; k++) exp_data[k] = v ? 64'(16 * t + 4 * b + k) : 64'd0;
    check({tag, ".valid"}, 256'(out_valid), 256'(v));
    check({tag, ".tid"},   256'(out_tid),   256'(v ? t : 2'd0));
    check({tag, ".data"},  256'(out_data),  256'(exp_data));
    check({tag, ".flags"}, 256'({out_sop, out_eop, s_start, s_done, rel, busy}),
          256'({sop, eop, st, sd, rl, bsy}));
  endtask

  function automatic void add_idle(input logic [3:0] d, input logic [3:0] e);
    vecs.push_back('{done: d, en: e, ready: 1'b1, valid: 1'b0, tid: 2'd0, beat: 1'b0,
                     sop: 1'b0, eop: 1'b0, start: 1'b0, sdone: 1'b0, rel: 1'b0, busy: 1'b0});
  endfunction

  function automatic void add_rel(input logic [3:0] d, input logic [3:0] e);
    vecs.push_back('{done: d, en: e, ready: 1'b1, valid: 1'b0, tid: 2'd0, beat: 1'b0,
                     sop: 1'b0, eop: 1'b0, start: 1'b0, sdone: 1'b0, rel: 1'b1, busy: 1'b1});
  endfunction

  function automatic void add_beat(input logic [3:0] e, input logic [1:0] t, input logic b,
                                   input logic st, input logic sd);
    vecs.push_back('{done: 4'd0, en: e, ready: 1'b1, valid: 1'b1, tid: t, beat: b,
                     sop: !b, eop: b, start: st, sdone: sd, rel: 1'b0, busy: 1'b1});
  endfunction

  function automatic void add_full_stream();
    for (int t = 0; t < 4; t++)
      for (int b = 0; b < 2; b++)
        add_beat(4'hF, 2'(t), 1'(b), (t == 0) && (b == 0), (t == 3) && (b == 1));
  endfunction

  initial begin
    int idx;
    for (int t = 0; t < 4; t++)
      for (int n = 0; n < 8; n++) gather[t][n] = 64'(16 * t + n);
    for (int n = 0; n < 4; n++) gather1[0][n] = 64'(n);

    // Basic ordered stream with done in order 3,0,2,1; thread 2 re-pulses in RELEASE.
    add_idle(4'b1000, 4'hF); add_idle(4'b0001, 4'hF); add_idle(4'b0100, 4'hF);
    add_idle(4'b0010, 4'hF); add_idle(4'b0000, 4'hF);
    add_full_stream();
    add_rel(4'b0100, 4'hF);
    // Only bit 2 survives: threads 0,1 alone cannot sync, thread 3 completes it.
    add_idle(4'b0001, 4'hF); add_idle(4'b0010, 4'hF); add_idle(4'b0000, 4'hF);
    add_idle(4'b0000, 4'hF); add_idle(4'b1000, 4'hF); add_idle(4'b0000, 4'hF);
    add_full_stream();
    add_rel(4'b0000, 4'hF); add_idle(4'b0000, 4'hF);
    // Mask 1010; live mask changes to 0101 mid-stream and must be ignored.
    add_idle(4'b0010, 4'b1010); add_idle(4'b1000, 4'b1010); add_idle(4'b0000, 4'b1010);
    add_beat(4'b1010, 2'd1, 1'b0, 1'b1, 1'b0);
    add_beat(4'b0101, 2'd1, 1'b1, 1'b0, 1'b0);
    add_beat(4'b0101, 2'd3, 1'b0, 1'b0, 1'b0);
    add_beat(4'b0101, 2'd3, 1'b1, 1'b0, 1'b1);
    add_rel(4'b0000, 4'b0101); add_idle(4'b0000, 4'b0101);
    // All-zero mask never syncs, even with every done bit set.
    add_idle(4'b1111, 4'b0000); add_idle(4'b0000, 4'b0000); add_idle(4'b0000, 4'b0000);
    add_idle(4'b0000, 4'b0001);
    add_beat(4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
    add_beat(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    add_rel(4'b0000, 4'b0001); add_idle(4'b0000, 4'b0001);

    reset_n = 1'b0; done = '0; en = 4'hF; out_ready = 1'b1;
    done1 = '0; en1 = 1'b1; out_ready1 = 1'b1;
    repeat (3) @(posedge clock);
    #2 check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock) reset_n = 1'b1;
    #1 check_outs("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clock);
      done = vecs[i].done; en = vecs[i].en; out_ready = vecs[i].ready;
      #1 check_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].tid, vecs[i].beat,
                    vecs[i].sop, vecs[i].eop, vecs[i].start, vecs[i].sdone,
                    vecs[i].rel, vecs[i].busy);
    end

    // Backpressure: ready toggles every cycle, starting with a stall.
    @(negedge clock) begin done = 4'hF; en = 4'hF; out_ready = 1'b0; end
    #1 check_outs("bp.lat0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock) done = '0;
    #1 check_outs("bp.lat1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      @(negedge clock) out_ready = cyc[0];
      #1 check_outs($sformatf("bp.c%0d", cyc), 1, 2'(idx / 2), 1'(idx % 2), (idx % 2) == 0,
                    (idx % 2) == 1, idx == 0, idx == 7, 0, 1);
      if (out_ready) idx++;
    end
    check("bp.beats", 256'(idx), 256'(8));
    @(negedge clock) out_ready = 1'b1;
    #1 check_outs("bp.rel", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clock);
    #1 check_outs("bp.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted during beat 3, then a fresh iteration restarts from tid 0 beat 0.
    @(negedge clock) done = 4'hF;
    @(negedge clock) done = '0;
    @(negedge clock);
    #1 check_outs("rst.b1", 1, 0, 0, 1, 0, 1, 0, 0, 1);
    @(negedge clock);
    @(negedge clock);
    #1 check_outs("rst.b3", 1, 1, 0, 1, 0, 0, 0, 0, 1);
    #2 reset_n = 1'b0;
    #1 check_outs("rst.in", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    #1 check_outs("rst.hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge clock);
    #1 check_outs("rst.after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock) done = 4'hF;
    @(negedge clock) done = '0;
    #1 check_outs("rst.lat", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      #1 check_outs($sformatf("rst.beat%0d", i), 1, 2'(i / 2), 1'(i % 2), (i % 2) == 0,
                    (i % 2) == 1, i == 0, i == 7, 0, 1);
    end
    @(negedge clock);
    #1 check_outs("rst.rel", 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Single thread, single beat: all four framing flags together.
    @(negedge clock) done1 = 1'b1;
    #1 check("deg.idle", 256'({out_valid1, busy1}), 256'(2'b00));
    @(negedge clock) done1 = 1'b0;
    #1 check("deg.lat", 256'({out_valid1, busy1}), 256'(2'b00));
    @(negedge clock);
    #1 begin
      check("deg.flags", 256'({out_valid1, out_sop1, out_eop1, s_start1, s_done1, rel1, busy1}),
            256'(7'b1111101));
      check("deg.tid", 256'(out_tid1), 256'(0));
      check("deg.data", 256'(out_data1), {64'd3, 64'd2, 64'd1, 64'd0});
    end
    @(negedge clock);
    #1 check("deg.rel", 256'({out_valid1, rel1, busy1}), 256'(3'b011));
    @(negedge clock);
    #1 check("deg.done", 256'({out_valid1, rel1, busy1}), 256'(3'b000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmp_ordered_serializer.md
# dmp_ordered_serializer

Parametrised successor to the gather-stage serializer in the DMP PageRank pipeline. It collects per-thread done pulses from `NUM_HW_THREADS` gather threads and, once every enabled thread has finished, streams each enabled thread's partition in ascending thread-ID order. Each partition is sent as `NODES_IN_GRAPH/BEAT_NODES` beats over a valid/ready interface with backpressure. After the last beat is accepted, it issues a release pulse so the threads can start the next iteration.

## Interface
- `NUM_HW_THREADS`, 8: number of gather threads / partitions (>=1).
- `NODES_IN_GRAPH`, 32: nodes per partition.
- `BEAT_NODES`, 8: nodes per output beat; must divide `NODES_IN_GRAPH`. `BEATS = NODES_IN_GRAPH/BEAT_NODES`.
- `DATA_WIDTH`, 64: bits per PageRank value.
- `TID_W`, derived: `max(1, $clog2(NUM_HW_THREADS))`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `page_rank_gather`  in  `[DATA_WIDTH-1:0]` x `[NUM_HW_THREADS][NODES_IN_GRAPH]`  per-thread partition values.
- `done`  in  `[NUM_HW_THREADS]`  one-cycle pulse per thread per iteration.
- `thread_enable`  in  `[NUM_HW_THREADS]`  active-thread mask.
- `out_data`  out  `[DATA_WIDTH-1:0]` x `[BEAT_NODES]`  beat payload.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_thread_id`  out  `TID_W`  thread of the current beat.
- `out_sop`  out  1  first beat of a thread.
- `out_eop`  out  1  last beat of a thread.
- `stream_start`  out  1  first beat of the iteration.
- `stream_done`  out  1  last beat of the iteration.
- `release`  out  1  one-cycle pulse: gather threads may restart.
- `busy`  out  1  state != WAIT.

## Operation
- `done_seen[i]` is a sticky register, set by `done[i]` in any state.
  - Cleared in the RELEASE cycle.
  - A `done[i]` pulse in the same cycle wins, so that bit stays set.
- `sync = |thread_enable && &(done_seen | ~thread_enable)`. An all-zero mask never syncs.
- `page_rank_gather[i]` must stay stable from `done[i]` until `release`.
- State machine:
  - WAIT: on `sync`, latch `thread_enable` into `en_q`. Set `tid` = lowest set bit of `en_q`, `beat` = 0. Go to SEND.
  - SEND: `out_valid` = 1. On handshake (`out_valid && out_ready`):
    - if `beat < BEATS-1`: `beat++`.
    - else if a higher enabled thread exists in `en_q`: `tid` = next higher enabled thread, `beat` = 0.
    - else: go to RELEASE.
  - RELEASE: `release` = 1 for one cycle, clear `done_seen`, go to WAIT.
- Enabled-thread mask: `thread_enable` changes after the WAIT-to-SEND transition are ignored until the next WAIT.
- Beat outputs (combinational from `tid`/`beat`, gated by `out_valid`, zero when `out_valid` = 0):
  - `out_data[k] = page_rank_gather[tid][beat*BEAT_NODES+k]`.
  - `out_sop = (beat == 0)`; `out_eop = (beat == BEATS-1)`.
  - `stream_start = out_sop` on the first enabled thread.
  - `stream_done = out_eop` on the last enabled thread.
- Backpressure: while `out_valid && !out_ready`, all outputs hold stable.
- Single enabled thread with `BEATS == 1`: its one beat asserts `out_sop`, `out_eop`, `stream_start` and `stream_done` together.

## Timing
- Reset (asynchronous, any state, including mid-stream): state = WAIT, `done_seen` = 0, `en_q` = 0, `tid` = 0, `beat` = 0.
  - All outputs 0 while in reset and the first cycle after.
  - A partially sent stream is abandoned and is not resumed.
- Latency:
  - Last `done` pulse in cycle N → `done_seen` complete in N+1 → `out_valid` = 1 in N+2.
  - With `out_ready` held at 1, an iteration takes exactly `popcount(en_q)*BEATS` consecutive valid cycles.
- Release timing:
  - `release` asserts the cycle after the `stream_done` handshake.
  - `busy` drops the cycle after `release`.
  - The earliest next `out_valid` is 2 cycles after `release` when done pulses coincide with it.
- One beat per cycle maximum; no bubbles between threads.

## Test plan
Unless stated, configuration is `NUM_HW_THREADS=4`, `NODES_IN_GRAPH=8`, `BEAT_NODES=4`, `DATA_WIDTH=64`, with `page_rank_gather[t][n] = 16*t + n`.

- Basic ordered stream: `done` pulses for threads 3,0,2,1 in separate cycles, mask 4'b1111, `out_ready` = 1.
  - 8 beats: tid 0,0,1,1,2,2,3,3; first beat data {0,1,2,3}.
  - `stream_start` on beat 1, `stream_done` on beat 8.
  - `release` one cycle later.
- Masked threads: mask 4'b1010, done on threads 1 and 3 only.
  - Beats for tid 1,1,3,3 only; `out_sop` on beats 1 and 3.
  - Sync occurs without done from threads 0 and 2.
- Backpressure: `out_ready` toggles 0/1 every cycle. Same 8-beat order; data and flags stable during each stall.
- Done in RELEASE: thread 2 pulses `done` in the RELEASE cycle. `done_seen[2]` remains 1; the other bits clear.
- Reset mid-stream: assert `reset_n` = 0 during beat 3.
  - All outputs 0, `busy` = 0.
  - A fresh full set of done pulses restarts from tid 0, beat 0.
- Degenerate configuration: `NUM_HW_THREADS=1`, `BEATS=1`. A single beat asserts `out_sop`, `out_eop`, `stream_start` and `stream_done` simultaneously.
